// File: rtl/coeff_commit_seq_if.sv
// Coefficient staging bus between the register block and the commit sequencer.
// master = upstream control (stages entries, requests commit/abort),
// slave  = the sequencer (drives the paced coefficient bus and status).
interface coeff_commit_seq_if #(
    parameter int ADR_BITS = 8,
    parameter int DAT_BITS = 18,
    parameter int DEPTH    = 64
);
    localparam int CNT_BITS = $clog2(DEPTH) + 1;

    logic [ADR_BITS-1:0] wr_adr_i;
    logic [DAT_BITS-1:0] wr_dat_i;
    logic                wr_valid_i;
    logic                wr_ready_o;
    logic                apply_i;
    logic                abort_i;
    logic [ADR_BITS-1:0] coeff_adr_o;
    logic [DAT_BITS-1:0] coeff_dat_o;
    logic                coeff_wr_o;
    logic                coeff_update_o;
    logic                busy_o;
    logic                done_o;
    logic                aborted_o;
    logic [CNT_BITS-1:0] count_o;

    modport master (
        output wr_adr_i, wr_dat_i, wr_valid_i, apply_i, abort_i,
        input  wr_ready_o, coeff_adr_o, coeff_dat_o, coeff_wr_o,
               coeff_update_o, busy_o, done_o, aborted_o, count_o
    );

    modport slave (
        input  wr_adr_i, wr_dat_i, wr_valid_i, apply_i, abort_i,
        output wr_ready_o, coeff_adr_o, coeff_dat_o, coeff_wr_o,
               coeff_update_o, busy_o, done_o, aborted_o, count_o
    );
endinterface

// File: rtl/coeff_commit_seq.sv
// Coefficient commit sequencer: stages (address, data) pairs in a FIFO and,
// on apply, replays them as paced coeff_wr strobes followed by a single
// coeff_update pulse so every filter stage switches coefficients together.
module coeff_commit_seq #(
    parameter int ADR_BITS = 8,
    parameter int DAT_BITS = 18,
    parameter int DEPTH    = 64,
    parameter int GAP      = 1,
    parameter int SETTLE   = 2
) (
    input logic          aclk,
    input logic          aclk_rstn,
    coeff_commit_seq_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int MAXC  = (GAP > SETTLE) ? GAP : SETTLE;
    localparam int TW    = $clog2(MAXC + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_GAP,
        S_SETTLE,
        S_UPDATE
    } state_t;

    state_t              state;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [CW-1:0]       count;
    logic [TW-1:0]       gap_cnt;
    logic [TW-1:0]       settle_cnt;

    logic [ADR_BITS-1:0] mem_adr [DEPTH];
    logic [DAT_BITS-1:0] mem_dat [DEPTH];

    logic                wr_ready_q;
    logic [ADR_BITS-1:0] coeff_adr_q;
    logic [DAT_BITS-1:0] coeff_dat_q;
    logic                coeff_wr_q;
    logic                coeff_update_q;
    logic                busy_q;
    logic                done_q;
    logic                aborted_q;

    logic                push;
    logic [CW-1:0]       count_inc;

    // An abort on the same edge as a stage request always drops the entry.
    assign push      = (state == S_IDLE) && bus.wr_valid_i && wr_ready_q && !bus.abort_i;
    assign count_inc = count + CW'(push);

    assign bus.wr_ready_o     = wr_ready_q;
    assign bus.coeff_adr_o    = coeff_adr_q;
    assign bus.coeff_dat_o    = coeff_dat_q;
    assign bus.coeff_wr_o     = coeff_wr_q;
    assign bus.coeff_update_o = coeff_update_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.aborted_o      = aborted_q;
    assign bus.count_o        = count;

    // Staging storage; contents need no reset because count/pointers gate every read.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_adr[wr_ptr] <= bus.wr_adr_i;
            mem_dat[wr_ptr] <= bus.wr_dat_i;
        end
    end

    // Commit sequencer: staging, paced drain, settle delay, update and abort handling.
    always_ff @(posedge aclk or negedge aclk_rstn) begin
        if (!aclk_rstn) begin
            state          <= S_IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            gap_cnt        <= '0;
            settle_cnt     <= '0;
            wr_ready_q     <= 1'b0;
            coeff_adr_q    <= '0;
            coeff_dat_q    <= '0;
            coeff_wr_q     <= 1'b0;
            coeff_update_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            coeff_wr_q     <= 1'b0;
            coeff_update_q <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            busy_q         <= (state != S_IDLE);

            unique case (state)
                S_IDLE: begin
                    if (bus.abort_i) begin
                        rd_ptr     <= wr_ptr;
                        count      <= '0;
                        aborted_q  <= 1'b1;
                        wr_ready_q <= 1'b1;
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                        count <= count_inc;
                        if (bus.apply_i) begin
                            wr_ready_q <= 1'b0;
                            if (count_inc != '0) begin
                                state <= S_DRAIN;
                            end else begin
                                state      <= S_SETTLE;
                                settle_cnt <= '0;
                            end
                        end else begin
                            wr_ready_q <= (count_inc != CW'(DEPTH));
                        end
                    end
                end

                S_DRAIN: begin
                    if (bus.abort_i) begin
                        state      <= S_IDLE;
                        rd_ptr     <= wr_ptr;
                        count      <= '0;
                        aborted_q  <= 1'b1;
                        wr_ready_q <= 1'b1;
                    end else begin
                        coeff_wr_q  <= 1'b1;
                        coeff_adr_q <= mem_adr[rd_ptr];
                        coeff_dat_q <= mem_dat[rd_ptr];
                        rd_ptr      <= rd_ptr + AW'(1);
                        count       <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                        end else if (GAP != 0) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end

                S_GAP: begin
                    if (bus.abort_i) begin
                        state      <= S_IDLE;
                        rd_ptr     <= wr_ptr;
                        count      <= '0;
                        aborted_q  <= 1'b1;
                        wr_ready_q <= 1'b1;
                    end else if (gap_cnt == TW'(GAP - 1)) begin
                        state <= S_DRAIN;
                    end else begin
                        gap_cnt <= gap_cnt + TW'(1);
                    end
                end

                S_SETTLE: begin
                    if (bus.abort_i) begin
                        state      <= S_IDLE;
                        rd_ptr     <= wr_ptr;
                        count      <= '0;
                        aborted_q  <= 1'b1;
                        wr_ready_q <= 1'b1;
                    end else if (settle_cnt == TW'(SETTLE)) begin
                        state          <= S_UPDATE;
                        coeff_update_q <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + TW'(1);
                    end
                end

                S_UPDATE: begin
                    state      <= S_IDLE;
                    done_q     <= 1'b1;
                    wr_ready_q <= (count != CW'(DEPTH));
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_coeff_commit_seq.sv
// Self-checking bench for coeff_commit_seq: staged entries are mirrored in a
// queue, and expected strobe/update/done edges are computed arithmetically.
module tb_coeff_commit_seq;
    localparam int ADR    = 8;
    localparam int DAT    = 18;
    localparam int DEPTH  = 64;
    localparam int GAP    = 1;
    localparam int SETTLE = 2;

    typedef struct {
        logic [ADR-1:0] a;
        logic [DAT-1:0] d;
    } ent_t;

    typedef struct {
        int             c;
        logic [ADR-1:0] a;
        logic [DAT-1:0] d;
    } wr_rec_t;

    logic aclk = 1'b0;
    logic aclk_rstn = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    ent_t    model_q[$];
    wr_rec_t wr_log[$];
    int      upd_log[$];
    int      done_log[$];
    int      abort_log[$];

    coeff_commit_seq_if #(.ADR_BITS(ADR), .DAT_BITS(DAT), .DEPTH(DEPTH)) bus ();

    coeff_commit_seq #(
        .ADR_BITS(ADR), .DAT_BITS(DAT), .DEPTH(DEPTH), .GAP(GAP), .SETTLE(SETTLE)
    ) dut (
        .aclk     (aclk),
        .aclk_rstn(aclk_rstn),
        .bus      (bus)
    );

    // Free-running clock.
    always #5 aclk = ~aclk;

    // Edge counter: value seen at a negedge is the index of the latest posedge.
    always @(posedge aclk) cyc <= cyc + 1;

    // Event monitor, sampling away from the active edge.
    always @(negedge aclk) begin
        if (bus.coeff_wr_o === 1'b1)     wr_log.push_back('{cyc, bus.coeff_adr_o, bus.coeff_dat_o});
        if (bus.coeff_update_o === 1'b1) upd_log.push_back(cyc);
        if (bus.done_o === 1'b1)         done_log.push_back(cyc);
        if (bus.aborted_o === 1'b1)      abort_log.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [ADR-1:0] a, input logic [DAT-1:0] d,
                                 input logic ap, input logic ab);
        bus.wr_valid_i = v;
        bus.wr_adr_i   = a;
        bus.wr_dat_i   = d;
        bus.apply_i    = ap;
        bus.abort_i    = ab;
        @(negedge aclk);
    endtask

    task automatic clearLogs();
        wr_log.delete();
        upd_log.delete();
        done_log.delete();
        abort_log.delete();
    endtask

    task automatic pushStep(input logic v, input logic [ADR-1:0] a, input logic [DAT-1:0] d,
                            input logic ab);
        if (!ab) checkOutput("wr_ready", bus.wr_ready_o, model_q.size() < DEPTH);
        if (ab) model_q.delete();
        else if (v && model_q.size() < DEPTH) model_q.push_back('{a, d});
        applyStimulus(v, a, d, 1'b0, ab);
        checkOutput("count", bus.count_o, model_q.size());
    endtask

    task automatic stageRandom(input int n);
        for (int i = 0; i < n; i++) pushStep(1'b1, ADR'($urandom), DAT'($urandom), 1'b0);
    endtask

    task automatic checkStrobes(input string tag, input int e0, input int n);
        checkOutput({tag, "_nstrobes"}, wr_log.size(), n);
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            checkOutput({tag, "_wr_edge"}, wr_log[i].c, e0 + 1 + i * (GAP + 1));
            checkOutput({tag, "_wr_adr"},  wr_log[i].a, model_q[i].a);
            checkOutput({tag, "_wr_dat"},  wr_log[i].d, model_q[i].d);
        end
    endtask

    task automatic runCommit(input string tag);
        int n, e0, upd, done_e;
        n = model_q.size();
        checkOutput({tag, "_count_pre"}, bus.count_o, n);
        clearLogs();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        e0 = cyc;
        upd = ((n > 0) ? (e0 + 1 + (n - 1) * (GAP + 1)) : e0) + SETTLE + 1;
        done_e = upd + 1;
        checkOutput({tag, "_busy"}, bus.busy_o, 1'b0);
        while (cyc < done_e + 2) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
            checkOutput({tag, "_busy"}, bus.busy_o, (cyc >= e0 + 1) && (cyc <= done_e));
        end
        checkStrobes(tag, e0, n);
        checkOutput({tag, "_nupd"}, upd_log.size(), 1);
        if (upd_log.size() > 0) checkOutput({tag, "_upd_edge"}, upd_log[0], upd);
        checkOutput({tag, "_ndone"}, done_log.size(), 1);
        if (done_log.size() > 0) checkOutput({tag, "_done_edge"}, done_log[0], done_e);
        checkOutput({tag, "_nabort"}, abort_log.size(), 0);
        checkOutput({tag, "_count_post"}, bus.count_o, 0);
        checkOutput({tag, "_ready_post"}, bus.wr_ready_o, 1'b1);
        model_q.delete();
    endtask

    task automatic runAbortMid(input int j);
        int n, e0, ab_e;
        n = model_q.size();
        clearLogs();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        e0 = cyc;
        while (cyc < e0 + 1 + (j - 1) * (GAP + 1)) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        ab_e = cyc;
        checkOutput("abmid_count", bus.count_o, 0);
        checkOutput("abmid_ready", bus.wr_ready_o, 1'b1);
        repeat (n * (GAP + 1) + SETTLE + 6) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkStrobes("abmid", e0, j);
        checkOutput("abmid_nabort", abort_log.size(), 1);
        if (abort_log.size() > 0) checkOutput("abmid_abort_edge", abort_log[0], ab_e);
        checkOutput("abmid_nupd", upd_log.size(), 0);
        checkOutput("abmid_ndone", done_log.size(), 0);
        model_q.delete();
    endtask

    // Directed sequence of scenarios with randomized payloads.
    initial begin
        int e0, guard;
        bus.wr_valid_i = 1'b0;
        bus.wr_adr_i   = '0;
        bus.wr_dat_i   = '0;
        bus.apply_i    = 1'b0;
        bus.abort_i    = 1'b0;
        repeat (3) @(negedge aclk);

        // Reset state.
        checkOutput("rst_ready", bus.wr_ready_o, 1'b0);
        checkOutput("rst_count", bus.count_o, 0);
        checkOutput("rst_busy", bus.busy_o, 1'b0);
        checkOutput("rst_strobes", {bus.coeff_wr_o, bus.coeff_update_o, bus.done_o, bus.aborted_o}, 4'b0);
        checkOutput("rst_bus", {bus.coeff_adr_o, bus.coeff_dat_o}, 0);
        aclk_rstn = 1'b1;
        #1 checkOutput("release_ready_pre", bus.wr_ready_o, 1'b0);
        @(negedge aclk);
        checkOutput("release_ready_post", bus.wr_ready_o, 1'b1);

        // Three directed entries, paced commit.
        pushStep(1'b1, 8'h00, 18'h00011, 1'b0);
        pushStep(1'b1, 8'h21, 18'h3FFFF, 1'b0);
        pushStep(1'b1, 8'h40, 18'h00123, 1'b0);
        runCommit("three");

        // Update-only commit.
        runCommit("empty");

        // Overfill: only DEPTH of 70 accepted.
        stageRandom(70);
        checkOutput("full_ready", bus.wr_ready_o, 1'b0);
        checkOutput("full_count", bus.count_o, DEPTH);
        runCommit("full");

        // Refill with irregular valid to exercise pointer wrap ordering.
        guard = 0;
        while (model_q.size() < DEPTH && guard < 400) begin
            pushStep($urandom_range(0, 3) != 0, ADR'($urandom), DAT'($urandom), 1'b0);
            guard++;
        end
        checkOutput("wrap_fill", model_q.size(), DEPTH);
        runCommit("wrap");

        // Abort after the second strobe of five.
        stageRandom(5);
        runAbortMid(2);

        // Apply and abort together.
        stageRandom(4);
        clearLogs();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        e0 = cyc;
        model_q.delete();
        checkOutput("apab_count", bus.count_o, 0);
        repeat (8) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("apab_nabort", abort_log.size(), 1);
        if (abort_log.size() > 0) checkOutput("apab_abort_edge", abort_log[0], e0);
        checkOutput("apab_nstrobes", wr_log.size(), 0);
        checkOutput("apab_nupd", upd_log.size(), 0);

        // Stage request and abort together.
        stageRandom(2);
        pushStep(1'b1, ADR'($urandom), DAT'($urandom), 1'b1);
        checkOutput("vab_ready", bus.wr_ready_o, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("vab_count", bus.count_o, 0);

        // Reset after the first strobe of four.
        stageRandom(4);
        clearLogs();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        e0 = cyc;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #2 aclk_rstn = 1'b0;
        #1;
        checkOutput("mrst_wr", bus.coeff_wr_o, 1'b0);
        checkOutput("mrst_flags", {bus.coeff_update_o, bus.done_o, bus.aborted_o, bus.busy_o, bus.wr_ready_o}, 5'b0);
        checkOutput("mrst_count", bus.count_o, 0);
        checkOutput("mrst_bus", {bus.coeff_adr_o, bus.coeff_dat_o}, 0);
        model_q.delete();
        repeat (2) @(negedge aclk);
        aclk_rstn = 1'b1;
        @(negedge aclk);
        checkOutput("mrst_ready_after", bus.wr_ready_o, 1'b1);
        checkOutput("mrst_count_after", bus.count_o, 0);
        repeat (15) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("mrst_nstrobes", wr_log.size(), 1);
        if (wr_log.size() > 0) checkOutput("mrst_wr_edge", wr_log[0].c, e0 + 1);
        checkOutput("mrst_nupd", upd_log.size(), 0);
        checkOutput("mrst_ndone", done_log.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
